ddram_arb: RTL and testbench
============================

# ddram_arb

Two-client arbiter that shares the single DDRAM Avalon-style port (DDRAM_*) of `emu` between two requesters. Client 0 is the video/framebuffer fetch side; client 1 is the loader/CPU side. It grants one whole burst at a time, read or write, with either round-robin or fixed priority. It routes read data back to the owner only and ties DDRAM_CLK to the system clock.

## Interface
Parameters:
- PRIO0, default 0: 1 means client 0 always wins a contended grant; 0 means round-robin.

Ports:
- clk  in  1  system clock (clk_sys); DDRAM_CLK is driven from it.
- reset_n  in  1  reset, synchronous, active-low.
- cN_rd  in  1  client N read request, N = 0,1; held until accepted.
- cN_we  in  1  client N write beat valid; held until accepted.
- cN_addr  in  29  client N address, 64-bit word units.
- cN_burstcnt  in  8  client N burst length in beats; 0 is treated as 1.
- cN_din  in  64  client N write data.
- cN_be  in  8  client N byte enables.
- cN_busy  out  1  client N stall; a beat or command is accepted on the cycle (cN_rd|cN_we)&!cN_busy.
- cN_dout  out  64  read data; DDRAM_DOUT is broadcast to both clients.
- cN_dout_ready  out  1  read beat valid, asserted for the owner only.
- DDRAM_CLK, DDRAM_BUSY, DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_DOUT, DDRAM_DOUT_READY, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE: same directions and widths as the `emu` DDRAM port (8/29/64/64/8 bits).

## Operation
States: IDLE, GRANT, RD_DATA, WR_BURST. Registered `owner` (1 bit), `last` (1 bit), `beats` (8 bits).

- **IDLE**
  - Both cN_busy are 1. DDRAM_RD and DDRAM_WE are 0. DDRAM_DOUT_READY is ignored.
  - A request is cN_rd|cN_we.
  - Only one client requesting: that client becomes owner, next state GRANT.
  - Both requesting, PRIO0=1: client 0 becomes owner.
  - Both requesting, PRIO0=0: client !last becomes owner.
- **GRANT**
  - Owner fields pass combinationally to DDRAM_* (addr, burstcnt, din, be, rd, we).
  - Owner busy = DDRAM_BUSY. Non-owner busy = 1.
  - If owner asserts rd and we together, rd wins and DDRAM_WE is forced to 0.
  - Read accepted (DDRAM_RD & !DDRAM_BUSY):
    - If the burst length is ≤1 and DDRAM_DOUT_READY is asserted on that same cycle, the burst is already complete → IDLE.
    - Otherwise latch beats = max(burstcnt,1) → RD_DATA.
  - First write beat accepted:
    - Burst length ≤1 → IDLE.
    - Otherwise beats = max(burstcnt,1) − 1 → WR_BURST.
  - Owner drops both rd and we → IDLE; `last` is unchanged.
- **RD_DATA**
  - Both busy = 1. DDRAM_RD = 0.
  - owner dout_ready = DDRAM_DOUT_READY. Each valid beat decrements `beats`.
  - On the beat where `beats` = 1 → IDLE.
- **WR_BURST**
  - DDRAM_ADDR and DDRAM_BURSTCNT are held at the values latched on the first beat.
  - DIN, BE and WE pass through from the owner. Owner busy = DDRAM_BUSY.
  - Each accepted beat decrements `beats`. The accepted beat with `beats` = 1 → IDLE.
  - Owner deasserting we mid-burst only inserts gaps; the burst is never abandoned.
- **Bookkeeping:** on each transition back to IDLE after a completed burst, `last` <= owner.
- **Concurrency:** at most one burst is outstanding at any time. No read is issued while a read burst is in flight.

## Timing
- Reset (reset_n = 0 at a clk edge):
  - State IDLE, owner = 0, last = 1 (so client 0 wins the first tie), beats = 0.
  - All cN_busy = 1, cN_dout_ready = 0, DDRAM_RD = DDRAM_WE = 0.
  - Reset mid-burst abandons the transfer. Later DDRAM_DOUT_READY pulses are ignored (IDLE).
- Grant latency: request seen in IDLE at cycle t → GRANT at t+1. The earliest accept is t+1 if DDRAM_BUSY = 0.
- Return to IDLE costs one cycle: the next grant is 2 cycles after the last beat/accept. Back-to-back bursts therefore have a minimum 2-cycle gap.
- Read data: cN_dout_ready has zero added latency relative to DDRAM_DOUT_READY (combinational).
- Beat counting uses 8-bit `beats`; burstcnt 255 completes after exactly 255 beats, with no wrap.

## Test plan
- **Single client read.** Reset, then c0_rd with addr 0x100 and burstcnt 4, DDRAM_BUSY = 0, memory model returns 4 beats after 5 cycles.
  - DDRAM_RD is high for exactly 1 cycle with ADDR 0x100, BURSTCNT 4.
  - c0_dout_ready pulses 4 times; c1_dout_ready stays 0; state IDLE after the 4th beat.
- **Contention, round-robin (PRIO0=0).** Both clients issue 1-beat reads continuously.
  - Grants alternate 0,1,0,1.
  - Each grant starts 2 cycles after the previous read completes.
- **PRIO0=1.** Same stimulus as above.
  - Client 0 is served every time; c1_busy stays 1 throughout.
- **Write burst with stalls.** c1_we, burstcnt 3, data A,B,C; DDRAM_BUSY high on the 2nd beat for 2 cycles; c1 drops we for 1 cycle after beat 2.
  - Exactly 3 DDRAM_WE&!BUSY beats carry A,B,C, each at the first-beat address.
  - c0_busy stays 1 throughout.
- **burstcnt 0.** A read with burstcnt 0 is treated as 1 beat; the arbiter returns to IDLE after 1 DOUT_READY.
- **Reset mid-read.** Assert reset_n = 0 after 2 of 8 beats, then release.
  - Outputs return to reset values.
  - Remaining DOUT_READY pulses produce no cN_dout_ready.
  - A new c1 request is granted normally.

Source files
------------

// File: rtl/ddram_arb.sv
// ddram_arb -- shares the single DDRAM Avalon-style port between two clients.
//   Client 0: video/framebuffer fetch.  Client 1: loader/CPU.
//   One whole burst (read or write) is granted at a time. Contended grants go
//   round-robin, or always to client 0 when PRIO0 = 1.
//
// Ports
//   clk, reset_n           system clock; synchronous active-low reset
//   cN_rd / cN_we          read request / write beat valid, held until accepted
//   cN_addr, cN_burstcnt   64-bit word address, burst length (0 behaves as 1)
//   cN_din, cN_be          write data / byte enables
//   cN_busy                stall; accept = (cN_rd|cN_we) & !cN_busy
//   cN_dout, cN_dout_ready read data (broadcast) / beat valid (owner only)
//   DDRAM_*                memory-side port; DDRAM_CLK is clk
module ddram_arb #(
   parameter bit PRIO0 = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,

   input  logic        c0_rd,
   input  logic        c0_we,
   input  logic [28:0] c0_addr,
   input  logic [7:0]  c0_burstcnt,
   input  logic [63:0] c0_din,
   input  logic [7:0]  c0_be,
   output logic        c0_busy,
   output logic [63:0] c0_dout,
   output logic        c0_dout_ready,

   input  logic        c1_rd,
   input  logic        c1_we,
   input  logic [28:0] c1_addr,
   input  logic [7:0]  c1_burstcnt,
   input  logic [63:0] c1_din,
   input  logic [7:0]  c1_be,
   output logic        c1_busy,
   output logic [63:0] c1_dout,
   output logic        c1_dout_ready,

   output logic        DDRAM_CLK,
   input  logic        DDRAM_BUSY,
   output logic [7:0]  DDRAM_BURSTCNT,
   output logic [28:0] DDRAM_ADDR,
   input  logic [63:0] DDRAM_DOUT,
   input  logic        DDRAM_DOUT_READY,
   output logic        DDRAM_RD,
   output logic [63:0] DDRAM_DIN,
   output logic [7:0]  DDRAM_BE,
   output logic        DDRAM_WE
);

   typedef struct packed {
      logic        rd;
      logic        we;
      logic [28:0] addr;
      logic [7:0]  bc;
      logic [63:0] din;
      logic [7:0]  be;
   } req_t;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_RD    = 2'd2;
   localparam logic [1:0] S_WR    = 2'd3;

   logic [1:0]  state;
   logic        owner;
   logic        last;
   logic [7:0]  beats;
   logic [28:0] wr_addr;
   logic [7:0]  wr_bc;

   req_t [1:0]  req;
   req_t        cur;
   logic [1:0]  want;
   logic [7:0]  bc_n;
   logic        port_open;
   logic        own_rdy;
   logic        rd_acc;
   logic        we_acc;

   assign req[0] = {c0_rd, c0_we, c0_addr, c0_burstcnt, c0_din, c0_be};
   assign req[1] = {c1_rd, c1_we, c1_addr, c1_burstcnt, c1_din, c1_be};
   assign cur    = req[owner];
   assign want   = {c1_rd | c1_we, c0_rd | c0_we};
   assign bc_n   = (cur.bc == 8'd0) ? 8'd1 : cur.bc;

   // Address/length come straight from the owner while granting; during the
   // rest of a write burst they stay frozen at the first-beat values.
   always_comb begin
      DDRAM_RD       = 1'b0;
      DDRAM_WE       = 1'b0;
      DDRAM_ADDR     = wr_addr;
      DDRAM_BURSTCNT = wr_bc;
      port_open      = 1'b0;
      own_rdy        = 1'b0;
      case (state)
         S_GRANT: begin
            DDRAM_RD       = cur.rd;
            DDRAM_WE       = cur.we & ~cur.rd;   // read wins a rd+we collision
            DDRAM_ADDR     = cur.addr;
            DDRAM_BURSTCNT = bc_n;
            port_open      = 1'b1;
            // A 1-beat read can complete on its own accept cycle.
            own_rdy        = DDRAM_DOUT_READY & cur.rd & ~DDRAM_BUSY;
         end
         S_RD: own_rdy = DDRAM_DOUT_READY;
         S_WR: begin
            DDRAM_WE  = cur.we;
            port_open = 1'b1;
         end
         default: ;
      endcase
   end

   assign rd_acc = DDRAM_RD & ~DDRAM_BUSY;
   assign we_acc = DDRAM_WE & ~DDRAM_BUSY;

   assign c0_busy       = (port_open && !owner) ? DDRAM_BUSY : 1'b1;
   assign c1_busy       = (port_open &&  owner) ? DDRAM_BUSY : 1'b1;
   assign c0_dout_ready = own_rdy & ~owner;
   assign c1_dout_ready = own_rdy &  owner;
   assign c0_dout       = DDRAM_DOUT;
   assign c1_dout       = DDRAM_DOUT;

   assign DDRAM_CLK = clk;
   assign DDRAM_DIN = cur.din;
   assign DDRAM_BE  = cur.be;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         owner   <= 1'b0;
         last    <= 1'b1;   // client 0 wins the first tie
         beats   <= 8'd0;
         wr_addr <= 29'd0;
         wr_bc   <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (want != 2'b00) begin
                  state <= S_GRANT;
                  if (want == 2'b11) owner <= PRIO0 ? 1'b0 : ~last;
                  else               owner <= want[1];
               end
            end
            S_GRANT: begin
               if (rd_acc) begin
                  if (bc_n == 8'd1 && DDRAM_DOUT_READY) begin
                     state <= S_IDLE;
                     last  <= owner;
                  end else begin
                     beats <= bc_n;
                     state <= S_RD;
                  end
               end else if (we_acc) begin
                  wr_addr <= cur.addr;
                  wr_bc   <= bc_n;
                  if (bc_n == 8'd1) begin
                     state <= S_IDLE;
                     last  <= owner;
                  end else begin
                     beats <= bc_n - 8'd1;
                     state <= S_WR;
                  end
               end else if (!cur.rd && !cur.we) begin
                  // Request withdrawn before acceptance: not a completed burst.
                  state <= S_IDLE;
               end
            end
            S_RD: begin
               if (DDRAM_DOUT_READY) begin
                  beats <= beats - 8'd1;
                  if (beats == 8'd1) begin
                     state <= S_IDLE;
                     last  <= owner;
                  end
               end
            end
            S_WR: begin
               if (we_acc) begin
                  beats <= beats - 8'd1;
                  if (beats == 8'd1) begin
                     state <= S_IDLE;
                     last  <= owner;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddram_arb.sv
// Bench for ddram_arb: instance 0 is round-robin, instance 1 has PRIO0 = 1.
// Both see the same client stimulus; each has its own memory responder.
module tb_ddram_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        c0_rd, c0_we, c1_rd, c1_we;
   logic [28:0] c0_addr, c1_addr;
   logic [7:0]  c0_bc, c1_bc, c0_be, c1_be;
   logic [63:0] c0_din, c1_din;
   logic        ddr_busy;

   logic        o_c0_busy[2], o_c1_busy[2], o_c0_rdy[2], o_c1_rdy[2];
   logic        o_dclk[2], o_rd[2], o_we[2];
   logic [63:0] o_c0_dout[2], o_c1_dout[2], o_din[2];
   logic [7:0]  o_bc[2], o_be[2];
   logic [28:0] o_addr[2];
   logic [63:0] m_dout[2] = '{64'd0, 64'd0};
   logic        m_rdy[2]  = '{1'b0, 1'b0};

   for (genvar g = 0; g < 2; g++) begin : g_dut
      ddram_arb #(.PRIO0(g == 1)) u_arb (
         .clk(clk), .reset_n(reset_n),
         .c0_rd(c0_rd), .c0_we(c0_we), .c0_addr(c0_addr), .c0_burstcnt(c0_bc),
         .c0_din(c0_din), .c0_be(c0_be), .c0_busy(o_c0_busy[g]),
         .c0_dout(o_c0_dout[g]), .c0_dout_ready(o_c0_rdy[g]),
         .c1_rd(c1_rd), .c1_we(c1_we), .c1_addr(c1_addr), .c1_burstcnt(c1_bc),
         .c1_din(c1_din), .c1_be(c1_be), .c1_busy(o_c1_busy[g]),
         .c1_dout(o_c1_dout[g]), .c1_dout_ready(o_c1_rdy[g]),
         .DDRAM_CLK(o_dclk[g]), .DDRAM_BUSY(ddr_busy), .DDRAM_BURSTCNT(o_bc[g]),
         .DDRAM_ADDR(o_addr[g]), .DDRAM_DOUT(m_dout[g]), .DDRAM_DOUT_READY(m_rdy[g]),
         .DDRAM_RD(o_rd[g]), .DDRAM_DIN(o_din[g]), .DDRAM_BE(o_be[g]), .DDRAM_WE(o_we[g])
      );
   end

   // Memory responder: an accepted read returns max(bc,1) consecutive beats
   // starting 5 cycles later.
   int pend[2] = '{0, 0};
   int dly[2]  = '{0, 0};
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int p, d;
         p = pend[i];
         d = dly[i];
         if (m_rdy[i]) p = p - 1;
         if (o_rd[i] && !ddr_busy) begin
            p = p + ((o_bc[i] == 8'd0) ? 1 : int'(o_bc[i]));
            d = 4;
         end else if (d > 0) d = d - 1;
         m_rdy[i]  <= (p > 0 && d == 0);
         m_dout[i] <= m_dout[i] + 64'd1;
         pend[i]   <= p;
         dly[i]    <= d;
      end
   end

   // Monitor
   int cyc = 0;
   int rd_hi[2] = '{0, 0};
   int dr0[2] = '{0, 0};
   int dr1[2] = '{0, 0};
   int c0_open[2] = '{0, 0};
   int c1_open[2] = '{0, 0};
   int last_beat[2] = '{0, 0};
   logic [28:0] rd_addr[2];
   logic [7:0]  rd_bc[2];
   int gq0[$], gq1[$], gap0[$], gap1[$];
   logic [63:0] wq_d[$];
   logic [28:0] wq_a[$];
   logic [7:0]  wq_bc[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (o_rd[i]) begin
            rd_hi[i]   <= rd_hi[i] + 1;
            rd_addr[i] <= o_addr[i];
            rd_bc[i]   <= o_bc[i];
         end
         if (o_c0_rdy[i]) dr0[i] <= dr0[i] + 1;
         if (o_c1_rdy[i]) dr1[i] <= dr1[i] + 1;
         if (!o_c0_busy[i]) c0_open[i] <= c0_open[i] + 1;
         if (!o_c1_busy[i]) c1_open[i] <= c1_open[i] + 1;
         if (o_c0_rdy[i] || o_c1_rdy[i]) last_beat[i] <= cyc;
      end
      if (o_rd[0] && !ddr_busy) begin
         gq0.push_back(o_c0_busy[0] ? 1 : 0);
         gap0.push_back(cyc - last_beat[0]);
      end
      if (o_rd[1] && !ddr_busy) begin
         gq1.push_back(o_c0_busy[1] ? 1 : 0);
         gap1.push_back(cyc - last_beat[1]);
      end
      if (o_we[0] && !ddr_busy) begin
         wq_d.push_back(o_din[0]);
         wq_a.push_back(o_addr[0]);
         wq_bc.push_back(o_bc[0]);
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      c0_rd = 0; c0_we = 0; c1_rd = 0; c1_we = 0;
      c0_addr = '0; c1_addr = '0; c0_bc = '0; c1_bc = '0;
      c0_din = '0; c1_din = '0; c0_be = '0; c1_be = '0;
   endtask

   // Present one command/beat for client cl and wait (bounded) for acceptance.
   task automatic issue(input bit cl, input bit wr, input logic [28:0] a,
                        input logic [7:0] bc, input logic [63:0] d, output bit ok);
      if (!cl) begin
         c0_rd = !wr; c0_we = wr; c0_addr = a; c0_bc = bc; c0_din = d; c0_be = 8'hFF;
      end else begin
         c1_rd = !wr; c1_we = wr; c1_addr = a; c1_bc = bc; c1_din = d; c1_be = 8'hFF;
      end
      #1;
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
         if ((cl ? o_c1_busy[0] : o_c0_busy[0]) == 1'b0) ok = 1'b1;
         tick();
      end
      if (!cl) begin c0_rd = 0; c0_we = 0; end
      else     begin c1_rd = 0; c1_we = 0; end
   endtask

   typedef struct {
      bit          cl;
      bit          wr;
      logic [28:0] addr;
      logic [7:0]  bc;
      int          nbeats;
      logic [7:0]  exp_bc;
   } vec_t;

   task automatic run_vec(input vec_t v, input int idx);
      int rh, s0, s1, wq0, got;
      bit ok;
      string tag;
      tag = $sformatf("v%0d", idx);
      rh = rd_hi[0]; s0 = dr0[0]; s1 = dr1[0]; wq0 = wq_d.size();
      if (!v.wr) begin
         issue(v.cl, 1'b0, v.addr, v.bc, 64'd0, ok);
         chk({tag, "_accept"}, ok, 1);
         for (int k = 0; k < 300; k++) begin
            got = v.cl ? dr1[0] - s1 : dr0[0] - s0;
            if (got >= v.nbeats) break;
            tick();
         end
         repeat (3) tick();
         chk({tag, "_rd_cycles"}, rd_hi[0] - rh, 1);
         chk({tag, "_rd_addr"}, rd_addr[0], v.addr);
         chk({tag, "_rd_bc"}, rd_bc[0], v.exp_bc);
         chk({tag, "_own_beats"}, v.cl ? dr1[0] - s1 : dr0[0] - s0, v.nbeats);
         chk({tag, "_other_beats"}, v.cl ? dr0[0] - s0 : dr1[0] - s1, 0);
      end else begin
         for (int b = 0; b < v.nbeats; b++) begin
            issue(v.cl, 1'b1, v.addr, v.bc, 64'hD000_0000_0000_0000 + 64'(idx * 256 + b), ok);
            chk({tag, "_wr_accept"}, ok, 1);
         end
         tick();
         chk({tag, "_wr_beats"}, wq_d.size() - wq0, v.nbeats);
         for (int b = 0; b < v.nbeats && wq0 + b < wq_d.size(); b++) begin
            chk({tag, "_wr_data"}, wq_d[wq0 + b], 64'hD000_0000_0000_0000 + 64'(idx * 256 + b));
            chk({tag, "_wr_addr"}, wq_a[wq0 + b], v.addr);
            chk({tag, "_wr_bc"}, wq_bc[wq0 + b], v.exp_bc);
         end
      end
      chk({tag, "_idle_busy"}, {o_c0_busy[0], o_c1_busy[0], o_rd[0], o_we[0]}, 4'b1100);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vt[7];
      bit ok;
      int b0, b1, s, snap, gw, ow;

      vt[0] = '{cl: 0, wr: 0, addr: 29'h100,      bc: 8'd4,   nbeats: 4,   exp_bc: 8'd4};
      vt[1] = '{cl: 1, wr: 0, addr: 29'h2345,     bc: 8'd1,   nbeats: 1,   exp_bc: 8'd1};
      vt[2] = '{cl: 0, wr: 0, addr: 29'h55,       bc: 8'd0,   nbeats: 1,   exp_bc: 8'd1};
      vt[3] = '{cl: 1, wr: 0, addr: 29'h1ABCDE,   bc: 8'd255, nbeats: 255, exp_bc: 8'd255};
      vt[4] = '{cl: 0, wr: 1, addr: 29'h10,       bc: 8'd1,   nbeats: 1,   exp_bc: 8'd1};
      vt[5] = '{cl: 1, wr: 1, addr: 29'h1FFFFFFF, bc: 8'd3,   nbeats: 3,   exp_bc: 8'd3};
      vt[6] = '{cl: 0, wr: 1, addr: 29'h77,       bc: 8'd0,   nbeats: 1,   exp_bc: 8'd1};

      // Reset with a request pending: nothing may be granted during reset.
      idle_inputs();
      ddr_busy = 0;
      reset_n = 0;
      c0_rd = 1; c0_bc = 8'd1;
      repeat (3) tick();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_outs%0d", i),
             {o_c0_busy[i], o_c1_busy[i], o_c0_rdy[i], o_c1_rdy[i], o_rd[i], o_we[i]}, 6'b110000);
         chk($sformatf("rst_dout%0d", i), o_c1_dout[i], m_dout[i]);
      end
      c0_rd = 0;
      reset_n = 1;
      tick();

      for (int v = 0; v < 7; v++) run_vec(vt[v], v);

      // Contention: both clients hold 1-beat reads. Fresh reset so client 0
      // takes the first tie.
      reset_n = 0; tick(); reset_n = 1;
      b0 = gq0.size(); b1 = gq1.size(); ow = c1_open[1];
      c0_rd = 1; c0_addr = 29'h11; c0_bc = 8'd1;
      c1_rd = 1; c1_addr = 29'h22; c1_bc = 8'd1;
      for (int k = 0; k < 200; k++) begin
         if (gq0.size() >= b0 + 4 && gq1.size() >= b1 + 4) break;
         tick();
      end
      c0_rd = 0; c1_rd = 0;
      ow = c1_open[1] - ow;
      repeat (15) tick();
      chk("rr_grants", gq0.size() - b0 >= 4, 1);
      chk("prio_grants", gq1.size() - b1 >= 4, 1);
      for (int k = 0; k < 4 && b0 + k < gq0.size() && b1 + k < gq1.size(); k++) begin
         chk($sformatf("rr_owner%0d", k), gq0[b0 + k], k % 2);
         chk($sformatf("prio_owner%0d", k), gq1[b1 + k], 0);
         if (k > 0) begin
            chk($sformatf("rr_gap%0d", k), gap0[b0 + k], 2);
            chk($sformatf("prio_gap%0d", k), gap1[b1 + k], 2);
         end
      end
      chk("prio_c1_busy", ow, 0);

      // Write burst with a memory stall and a client gap; the address moves
      // after the first beat but the port must keep the latched one.
      reset_n = 0; tick(); reset_n = 1; tick();
      gw = wq_d.size(); ow = c0_open[0];
      issue(1, 1, 29'h4000, 8'd3, 64'hAAAA, ok);
      chk("wst_acc_a", ok, 1);
      ddr_busy = 1;
      c1_we = 1; c1_din = 64'hBBBB; c1_addr = 29'h4001;
      tick();
      chk("wst_stall_busy", o_c1_busy[0], 1);
      tick();
      ddr_busy = 0;
      issue(1, 1, 29'h4001, 8'd3, 64'hBBBB, ok);
      chk("wst_acc_b", ok, 1);
      tick();
      issue(1, 1, 29'h4002, 8'd3, 64'hCCCC, ok);
      chk("wst_acc_c", ok, 1);
      tick();
      chk("wst_beats", wq_d.size() - gw, 3);
      if (wq_d.size() - gw == 3) begin
         chk("wst_d0", wq_d[gw],     64'hAAAA);
         chk("wst_d1", wq_d[gw + 1], 64'hBBBB);
         chk("wst_d2", wq_d[gw + 2], 64'hCCCC);
         chk("wst_a1", wq_a[gw + 1], 29'h4000);
         chk("wst_a2", wq_a[gw + 2], 29'h4000);
         chk("wst_bc2", wq_bc[gw + 2], 8'd3);
      end
      chk("wst_c0_busy", c0_open[0] - ow, 0);
      chk("wst_idle", {o_c0_busy[0], o_c1_busy[0], o_we[0]}, 3'b110);

      // Reset in the middle of an 8-beat read.
      s = dr0[0];
      issue(0, 0, 29'h300, 8'd8, 64'd0, ok);
      chk("rmr_accept", ok, 1);
      for (int k = 0; k < 40 && dr0[0] - s < 2; k++) tick();
      chk("rmr_two_beats", dr0[0] - s >= 2, 1);
      reset_n = 0;
      tick();
      chk("rmr_outs", {o_c0_busy[0], o_c1_busy[0], o_c0_rdy[0], o_c1_rdy[0], o_rd[0], o_we[0]},
          6'b110000);
      snap = dr0[0] + dr1[0];
      reset_n = 1;
      for (int k = 0; k < 40 && (pend[0] != 0 || m_rdy[0]); k++) tick();
      tick();
      chk("rmr_no_stale_beats", dr0[0] + dr1[0] - snap, 0);
      run_vec('{cl: 1, wr: 0, addr: 29'h500, bc: 8'd2, nbeats: 2, exp_bc: 8'd2}, 7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
